line_mem_responder: RTL
=======================

LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 8, cycles from request acceptance to mem_ready (legal range 1..255).
REQ-002 SHALL have parameter DEPTH_LOG2, default 6, log2 of stored 128-bit lines.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port proc_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_read  input  1  line read request from the cache.
REQ-006 SHALL have port mem_write  input  1  line write request from the cache.
REQ-007 SHALL have port mem_addr  input  28  line address.
REQ-008 SHALL have port mem_wdata  input  128  write line data.
REQ-009 SHALL have port mem_rdata  output  128  read line data.
REQ-010 SHALL have port mem_ready  output  1  one-cycle completion strobe.
REQ-011 SHALL have port mem_err  output  1  sticky protocol-error flag.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-013 In IDLE with mem_read or mem_write high, SHALL latch mem_addr, mem_wdata and op, load counter with LATENCY-1, and go to BUSY (RESP directly if LATENCY=1).
REQ-014 When mem_read and mem_write are both high in IDLE, write SHALL win.
REQ-015 In BUSY, counter SHALL decrement each cycle; at 0 the FSM SHALL move to RESP.
REQ-016 Request seen in IDLE in cycle c SHALL produce mem_ready=1 in exactly cycle c+LATENCY, and mem_ready SHALL be 0 in every other cycle.
REQ-017 In RESP for a read, mem_rdata SHALL equal line[latched addr[DEPTH_LOG2-1:0]] in the mem_ready cycle.
REQ-018 mem_rdata SHALL then hold that value until the next read response, because the requester consumes it one cycle after mem_ready.
REQ-019 In RESP for a write, the line SHALL be committed at the end of the mem_ready cycle, and mem_rdata SHALL be unchanged.
REQ-020 RESP SHALL always return to IDLE next cycle; a request present in that IDLE cycle SHALL be accepted (back-to-back, LATENCY+1 cycle period).
REQ-021 Request inputs SHALL be ignored in BUSY and RESP; the latched values alone govern the transaction.
REQ-022 Address bits above DEPTH_LOG2 SHALL be ignored, so addresses alias modulo 2^DEPTH_LOG2.

Reset
REQ-023 With proc_reset high at an edge: state=IDLE, counter=0, mem_ready=0, mem_rdata=0, mem_err=0.
REQ-024 Line storage contents SHALL be unaffected by reset.
REQ-025 Reset during BUSY or RESP SHALL abort the transaction, and a pending write SHALL NOT be committed.
REQ-026 A request held high through reset release SHALL be accepted in the first IDLE cycle after release.

Configuration
REQ-027 With macro LINE_MEM_RESP_ERR_EN defined, mem_err SHALL set, and stay set until reset, on either condition: mem_read and mem_write both high in IDLE, or mem_addr differing from the latched address in BUSY while mem_read or mem_write is high.
REQ-028 Without LINE_MEM_RESP_ERR_EN, mem_err SHALL be constant 0 and no comparison logic SHALL be built.

Structure
REQ-029 Shared package line_mem_pkg SHALL hold LINE_W=128, MEM_ADDR_W=28 and the IDLE/BUSY/RESP state encoding.
REQ-030 Storage SHALL be sub-module line_mem_array: one synchronous-write port, combinational read, 2^DEPTH_LOG2 x 128.
REQ-031 Counter width SHALL be $clog2(LATENCY+1).

Verification
REQ-032 Reset, then write addr 0x05, data 128'hA5..A5 (LATENCY=8) -> mem_ready exactly in cycle c+8; mem_rdata stays 0.
REQ-033 Read addr 0x05 -> mem_ready in cycle c+8, mem_rdata=128'hA5..A5; value still valid in cycle c+9 with mem_read low.
REQ-034 Back-to-back reads 0x05 then 0x45 (aliases, DEPTH_LOG2=6), second presented in the cycle after mem_ready -> second mem_ready 9 cycles after the first, data A5..A5.
REQ-035 Write 0x07 = 128'h1, reset asserted at cycle c+4, then read 0x07 -> mem_ready absent after reset; read returns the prior content, not 128'h1.
REQ-036 With LINE_MEM_RESP_ERR_EN: read and write high together in IDLE -> mem_err=1 next cycle, write performed; mem_err stays 1 until proc_reset; without the macro, same stimulus -> mem_err=0.
REQ-037 LATENCY=1: read 0x05 presented in cycle c -> mem_ready in cycle c+1, then idle; continuous mem_read -> mem_ready every 2nd cycle.

Source files
------------

// File: rtl/line_mem_pkg.sv
// Shared constants and FSM state encoding for the line memory responder.
package line_mem_pkg;
    localparam int LINE_W     = 128;
    localparam int MEM_ADDR_W = 28;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;
endpackage

// File: rtl/line_mem_array.sv
// Line storage: 2^DEPTH_LOG2 x LINE_W, one synchronous-write port, combinational read.
module line_mem_array
    import line_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [LINE_W-1:0]     wdata,
    output logic [LINE_W-1:0]     rdata
);
    logic [LINE_W-1:0] lines_q [2**DEPTH_LOG2];

    // Write port; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            lines_q[addr] <= wdata;
        end
    end

    assign rdata = lines_q[addr];
endmodule

// File: rtl/line_mem_responder.sv
// Fixed-latency 128-bit line memory responder (IDLE/BUSY/RESP).
// Optional sticky protocol-error detection enabled by macro LINE_MEM_RESP_ERR_EN.
module line_mem_responder
    import line_mem_pkg::*;
#(
    parameter int LATENCY    = 8,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  proc_reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0]     mem_wdata,
    output logic [LINE_W-1:0]     mem_rdata,
    output logic                  mem_ready,
    output logic                  mem_err
);
    localparam int               CNT_W    = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [MEM_ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]       wdata_q, wdata_d;
    logic                    op_wr_q, op_wr_d;
    logic                    ready_q, ready_d;
    logic [LINE_W-1:0]       rdata_q, rdata_d;
    logic                    line_we_s;
    logic [LINE_W-1:0]       line_rd_s;

    // Next-state, counter, request latch and response data.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        op_wr_d   = op_wr_q;
        rdata_d   = rdata_q;
        line_we_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    op_wr_d = mem_write;
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY == 1) ? RESP : BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                // Leaving on the last decrement lands RESP exactly LATENCY cycles after acceptance.
                if (cnt_q <= CNT_ONE) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                    state_d = BUSY;
                end
            end
            RESP: begin
                state_d   = IDLE;
                line_we_s = op_wr_q && !proc_reset;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if ((state_d == RESP) && (state_q != RESP) && !op_wr_d) begin
            rdata_d = line_rd_s;
        end else begin
            rdata_d = rdata_q;
        end
        ready_d = (state_d == RESP);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_wr_q <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_wr_q <= op_wr_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    line_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (line_we_s),
        .addr  (addr_d[DEPTH_LOG2-1:0]),
        .wdata (wdata_q),
        .rdata (line_rd_s)
    );

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;

`ifdef LINE_MEM_RESP_ERR_EN
    logic err_q, err_d;

    // Sticky error: simultaneous read/write, or address changing mid-transaction.
    always_comb begin
        err_d = err_q;
        if ((state_q == IDLE) && mem_read && mem_write) begin
            err_d = 1'b1;
        end else if ((state_q == BUSY) && (mem_read || mem_write) && (mem_addr != addr_q)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign mem_err = err_q;
`else
    logic addr_hi_unused_s;
    assign addr_hi_unused_s = ^addr_q[MEM_ADDR_W-1:DEPTH_LOG2];
    assign mem_err          = 1'b0;
`endif
endmodule
